serial_and_reducer: RTL

//   Consumes a stream of WIDTH-bit beats and forms the bitwise AND of each

---
 rtl/serial_and_reducer_if.sv | 38 +++
 rtl/serial_and_reducer.sv | 91 +++++++++
 2 files changed

// File: rtl/serial_and_reducer_if.sv
// Stream bundle for serial_and_reducer: upstream beat handshake with flush,
// downstream frame-result handshake, and the partial-frame status flag.
interface serial_and_reducer_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             flush;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  logic             busy;

  // Reducer side: consumes beats, produces frame results.
  modport slave (
    input  up_valid,
    input  up_data,
    input  flush,
    input  down_ready,
    output up_ready,
    output down_valid,
    output down_data,
    output busy
  );

  // Environment side: offers beats, takes frame results.
  modport master (
    output up_valid,
    output up_data,
    output flush,
    output down_ready,
    input  up_ready,
    input  down_valid,
    input  down_data,
    input  busy
  );
endinterface

// File: rtl/serial_and_reducer.sv
// serial_and_reducer: bitwise AND over each frame of FRAME_LEN beats.
// One registered output slot; a final beat is only stalled when that slot
// is still occupied and not being drained in the same cycle.
module serial_and_reducer #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_and_reducer_if.slave bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             down_valid_q, down_valid_d;
  logic [WIDTH-1:0] down_data_q, down_data_d;

  logic             is_last;
  logic             up_ready;
  logic             up_fire;
  logic             down_fire;
  logic             final_fire;
  logic [WIDTH-1:0] merged;

  // First beat of a frame seeds the accumulator; later beats AND into it.
  // With FRAME_LEN==1 the count never leaves 0, so the result is the beat.
  function automatic logic [WIDTH-1:0] frame_merge(
    input logic             first,
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] beat
  );
    return first ? beat : (acc & beat);
  endfunction

  assign is_last    = (beat_cnt_q == LAST_BEAT);
  // Only a final beat needs the output slot, so only it can be held off.
  assign up_ready   = !(is_last && down_valid_q && !bus.down_ready);
  assign up_fire    = bus.up_valid && up_ready;
  assign down_fire  = down_valid_q && bus.down_ready;
  // A flush in the same cycle cancels the frame, even on its last beat.
  assign final_fire = up_fire && is_last && !bus.flush;
  assign merged     = frame_merge(beat_cnt_q == '0, acc_q, bus.up_data);

  // Next-state for beat counter, accumulator and output slot.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    acc_d        = acc_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;

    if (bus.flush) begin
      beat_cnt_d = '0;
    end else if (up_fire) begin
      acc_d      = merged;
      beat_cnt_d = is_last ? '0 : beat_cnt_q + CNT_W'(1);
    end

    // A new result overwrites a slot being drained this cycle, so
    // back-to-back frames come out with no bubble.
    if (final_fire) begin
      down_valid_d = 1'b1;
      down_data_d  = merged;
    end else if (down_fire) begin
      down_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any partial frame and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      acc_q        <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      acc_q        <= acc_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end
  end

  assign bus.up_ready   = up_ready;
  assign bus.down_valid = down_valid_q;
  assign bus.down_data  = down_data_q;
  assign bus.busy       = (beat_cnt_q != '0);

endmodule
